// File: rtl/uart_ctrl_if.sv
// Bus and uart-side handshake bundle for uart_ctrl.
// slave is the controller's view; master is the SoC/uart side.
interface uart_ctrl_if;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_sent;
    logic [7:0] rx_data;
    logic       rx_received;

    modport slave (
        input  addr, wr_en, rd_en, wdata, tx_sent, rx_data, rx_received,
        output rdata, irq, tx_data, tx_send
    );

    modport master (
        output addr, wr_en, rd_en, wdata, tx_sent, rx_data, rx_received,
        input  rdata, irq, tx_data, tx_send
    );
endinterface

// File: rtl/uart_ctrl.sv
// Host-side controller for the uart core: TX/RX byte FIFOs, a small
// register file (DATA/STATUS/CTRL/RXCNT), sticky overflow flags and a
// level interrupt.
module uart_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_ctrl_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // TX FIFO state
    logic [7:0]           r_tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_tx_wp;
    logic [PTR_W-1:0]     r_tx_rp;
    logic [CNT_WIDTH-1:0] r_tx_cnt;

    // RX FIFO state
    logic [7:0]           r_rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_rx_wp;
    logic [PTR_W-1:0]     r_rx_rp;
    logic [CNT_WIDTH-1:0] r_rx_cnt;

    // Registers and flags
    logic       r_tx_ovf;
    logic       r_rx_ovr;
    logic [1:0] r_ctrl;
    logic [7:0] r_rdata;
    logic       r_irq;
    logic       r_rx_rcv_d;

    // Decoded strobes and FIFO status
    logic w_wr_data, w_wr_status, w_wr_ctrl, w_rd_data;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_pop, w_tx_push, w_tx_ovf_set;
    logic w_rx_edge, w_rx_pop, w_rx_push, w_rx_ovr_set;
    logic [7:0] w_status;

    // Next-state values (irq is computed from these)
    logic [CNT_WIDTH-1:0] w_tx_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_rx_cnt_nxt;
    logic                 w_tx_ovf_nxt;
    logic                 w_rx_ovr_nxt;
    logic [1:0]           w_ctrl_nxt;
    logic                 w_irq_nxt;

    assign w_wr_data   = bus.wr_en && (bus.addr == 2'd0);
    assign w_wr_status = bus.wr_en && (bus.addr == 2'd1);
    assign w_wr_ctrl   = bus.wr_en && (bus.addr == 2'd2);
    assign w_rd_data   = bus.rd_en && (bus.addr == 2'd0);

    assign w_tx_full  = (r_tx_cnt == CNT_WIDTH'(FIFO_DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CNT_WIDTH'(FIFO_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // accepted in that case and no overflow is flagged.
    assign w_tx_pop     = bus.tx_sent && !w_tx_empty;
    assign w_tx_push    = w_wr_data && (!w_tx_full || w_tx_pop);
    assign w_tx_ovf_set = w_wr_data && w_tx_full && !w_tx_pop;

    assign w_rx_edge    = bus.rx_received && !r_rx_rcv_d;
    assign w_rx_pop     = w_rd_data && !w_rx_empty;
    assign w_rx_push    = w_rx_edge && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr_set = w_rx_edge && w_rx_full && !w_rx_pop;

    assign w_status = {2'b00, r_tx_ovf, r_rx_ovr, w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};

    assign bus.tx_data = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];
    assign bus.tx_send = !w_tx_empty;
    assign bus.rdata   = r_rdata;
    assign bus.irq     = r_irq;

    // Next-state counts, flags (set beats clear), CTRL and interrupt level
    always_comb begin
        w_tx_cnt_nxt = r_tx_cnt;
        if (w_tx_push && !w_tx_pop)
            w_tx_cnt_nxt = r_tx_cnt + CNT_WIDTH'(1);
        else if (!w_tx_push && w_tx_pop)
            w_tx_cnt_nxt = r_tx_cnt - CNT_WIDTH'(1);

        w_rx_cnt_nxt = r_rx_cnt;
        if (w_rx_push && !w_rx_pop)
            w_rx_cnt_nxt = r_rx_cnt + CNT_WIDTH'(1);
        else if (!w_rx_push && w_rx_pop)
            w_rx_cnt_nxt = r_rx_cnt - CNT_WIDTH'(1);

        w_tx_ovf_nxt = r_tx_ovf;
        if (w_wr_status && bus.wdata[5])
            w_tx_ovf_nxt = 1'b0;
        if (w_tx_ovf_set)
            w_tx_ovf_nxt = 1'b1;

        w_rx_ovr_nxt = r_rx_ovr;
        if (w_wr_status && bus.wdata[4])
            w_rx_ovr_nxt = 1'b0;
        if (w_rx_ovr_set)
            w_rx_ovr_nxt = 1'b1;

        w_ctrl_nxt = r_ctrl;
        if (w_wr_ctrl)
            w_ctrl_nxt = bus.wdata[1:0];

        w_irq_nxt = (w_ctrl_nxt[0] && (w_rx_cnt_nxt != '0)) ||
                    (w_ctrl_nxt[1] && (w_tx_cnt_nxt == '0)) ||
                    w_rx_ovr_nxt || w_tx_ovf_nxt;
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp] <= bus.wdata;
        if (w_rx_push)
            r_rx_mem[r_rx_wp] <= bus.rx_data;
    end

    // Pointers, counters, flags, CTRL, irq and the rx_received edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_cnt   <= '0;
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_cnt   <= '0;
            r_tx_ovf   <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_ctrl     <= '0;
            r_irq      <= 1'b0;
            r_rx_rcv_d <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_W'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_W'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_W'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_W'(1);
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_tx_ovf   <= w_tx_ovf_nxt;
            r_rx_ovr   <= w_rx_ovr_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_irq      <= w_irq_nxt;
            r_rx_rcv_d <= bus.rx_received;
        end
    end

    // Registered read data; holds when no read strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (bus.rd_en) begin
            case (bus.addr)
                2'd0:    r_rdata <= w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
                2'd1:    r_rdata <= w_status;
                2'd2:    r_rdata <= {6'b000000, r_ctrl};
                default: r_rdata <= 8'(r_rx_cnt);
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: directed scenarios plus randomized
// traffic against a queue-based behavioural model.
module tb_uart_ctrl;

    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    uart_ctrl_if u_if ();

    uart_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] m_tx_q[$];
    logic [7:0] m_rx_q[$];
    logic       m_tx_ovf;
    logic       m_rx_ovr;
    logic [1:0] m_ctrl;
    logic [7:0] m_rdata;
    logic       m_irq;
    logic       m_rx_prev;

    task automatic model_reset();
        m_tx_q.delete();
        m_rx_q.delete();
        m_tx_ovf  = 1'b0;
        m_rx_ovr  = 1'b0;
        m_ctrl    = 2'b00;
        m_rdata   = 8'h00;
        m_irq     = 1'b0;
        m_rx_prev = 1'b0;
    endtask

    // Applies one clock edge worth of the currently driven inputs to the model
    task automatic model_update();
        int         txn, rxn;
        logic       txpop, rxpop, ovf_set, ovr_set, rx_edge;
        logic [7:0] st;
        txn = m_tx_q.size();
        rxn = m_rx_q.size();
        txpop = 1'b0; rxpop = 1'b0; ovf_set = 1'b0; ovr_set = 1'b0;
        st = {2'b00, m_tx_ovf, m_rx_ovr, (txn == DEPTH), (txn == 0), (rxn == DEPTH), (rxn != 0)};
        if (u_if.rd_en) begin
            case (u_if.addr)
                2'd0: begin
                    if (rxn > 0) begin
                        m_rdata = m_rx_q.pop_front();
                        rxpop = 1'b1;
                    end else begin
                        m_rdata = 8'h00;
                    end
                end
                2'd1:    m_rdata = st;
                2'd2:    m_rdata = {6'b000000, m_ctrl};
                default: m_rdata = 8'(rxn);
            endcase
        end
        if (u_if.tx_sent && txn > 0) begin
            void'(m_tx_q.pop_front());
            txpop = 1'b1;
        end
        if (u_if.wr_en && u_if.addr == 2'd0) begin
            if (txn < DEPTH || txpop) m_tx_q.push_back(u_if.wdata);
            else ovf_set = 1'b1;
        end
        rx_edge = u_if.rx_received && !m_rx_prev;
        m_rx_prev = u_if.rx_received;
        if (rx_edge) begin
            if (rxn < DEPTH || rxpop) m_rx_q.push_back(u_if.rx_data);
            else ovr_set = 1'b1;
        end
        if (u_if.wr_en && u_if.addr == 2'd1) begin
            if (u_if.wdata[4]) m_rx_ovr = 1'b0;
            if (u_if.wdata[5]) m_tx_ovf = 1'b0;
        end
        if (ovf_set) m_tx_ovf = 1'b1;
        if (ovr_set) m_rx_ovr = 1'b1;
        if (u_if.wr_en && u_if.addr == 2'd2) m_ctrl = u_if.wdata[1:0];
        m_irq = (m_ctrl[0] && m_rx_q.size() > 0) || (m_ctrl[1] && m_tx_q.size() == 0) ||
                m_rx_ovr || m_tx_ovf;
    endtask

    // One bus cycle: drive, clock, update model, settle to sample point
    task automatic step(input logic [1:0] a, input logic w, input logic r, input logic [7:0] wd,
                        input logic ts, input logic [7:0] rd8, input logic rr);
        u_if.addr = a; u_if.wr_en = w; u_if.rd_en = r; u_if.wdata = wd;
        u_if.tx_sent = ts; u_if.rx_data = rd8; u_if.rx_received = rr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();               step(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0); endtask
    task automatic wr(input logic [1:0] a, input logic [7:0] d); step(a, 1'b1, 1'b0, d, 1'b0, 8'h00, 1'b0); endtask
    task automatic rd(input logic [1:0] a); step(a, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0); endtask
    task automatic txs();                step(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0); endtask
    task automatic rxb(input logic [7:0] d);
        step(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, d, 1'b1);
        idle();
    endtask

    task automatic zero_inputs();
        u_if.addr = '0; u_if.wr_en = 1'b0; u_if.rd_en = 1'b0; u_if.wdata = '0;
        u_if.tx_sent = 1'b0; u_if.rx_data = '0; u_if.rx_received = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            u_if.addr = 2'($urandom); u_if.wr_en = 1'($urandom); u_if.rd_en = 1'($urandom);
            u_if.wdata = 8'($urandom); u_if.tx_sent = 1'($urandom);
            u_if.rx_data = 8'($urandom); u_if.rx_received = 1'($urandom);
            @(posedge clk); #1;
        end
        zero_inputs();
        model_reset();
        rst = 1'b1;
        idle();
        n_cmp++; if (u_if.rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got=%02h exp=00", u_if.rdata); end
        n_cmp++; if (u_if.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", u_if.irq); end
        n_cmp++; if (u_if.tx_send !== 1'b0) begin n_err++; $display("FAIL reset_tx_send got=%b exp=0", u_if.tx_send); end
        n_cmp++; if (u_if.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got=%02h exp=00", u_if.tx_data); end
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h04) begin n_err++; $display("FAIL reset_status got=%02h exp=04", u_if.rdata); end
    endtask

    task automatic test_tx_basic();
        wr(2'd0, 8'h55);
        wr(2'd0, 8'hA3);
        wr(2'd0, 8'h0F);
        n_cmp++; if (u_if.tx_send !== 1'b1 || u_if.tx_data !== 8'h55) begin
            n_err++; $display("FAIL tx_head0 got send=%b data=%02h exp send=1 data=55", u_if.tx_send, u_if.tx_data); end
        idle();
        n_cmp++; if (u_if.tx_data !== 8'h55) begin n_err++; $display("FAIL tx_hold got=%02h exp=55", u_if.tx_data); end
        txs();
        n_cmp++; if (u_if.tx_data !== 8'hA3) begin n_err++; $display("FAIL tx_head1 got=%02h exp=A3", u_if.tx_data); end
        txs();
        n_cmp++; if (u_if.tx_data !== 8'h0F) begin n_err++; $display("FAIL tx_head2 got=%02h exp=0F", u_if.tx_data); end
        txs();
        n_cmp++; if (u_if.tx_send !== 1'b0 || u_if.tx_data !== 8'h00) begin
            n_err++; $display("FAIL tx_drained got send=%b data=%02h exp send=0 data=00", u_if.tx_send, u_if.tx_data); end
        txs();
        n_cmp++; if (u_if.tx_send !== 1'b0) begin n_err++; $display("FAIL tx_sent_empty got=%b exp=0", u_if.tx_send); end
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < DEPTH + 1; i++) wr(2'd0, 8'(i + 1));
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h28) begin n_err++; $display("FAIL tx_ovf_status got=%02h exp=28", u_if.rdata); end
        n_cmp++; if (u_if.irq !== 1'b1) begin n_err++; $display("FAIL tx_ovf_irq got=%b exp=1", u_if.irq); end
        wr(2'd1, 8'h20);
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h08) begin n_err++; $display("FAIL tx_ovf_clear got=%02h exp=08", u_if.rdata); end
        // push on a full FIFO together with a tx_sent pop
        step(2'd0, 1'b1, 1'b0, 8'hEE, 1'b1, 8'h00, 1'b0);
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h08) begin n_err++; $display("FAIL tx_full_pushpop got=%02h exp=08", u_if.rdata); end
        n_cmp++; if (u_if.tx_data !== 8'h02) begin n_err++; $display("FAIL tx_full_head got=%02h exp=02", u_if.tx_data); end
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == DEPTH - 1) ? 8'hEE : 8'(i + 2);
            n_cmp++; if (u_if.tx_data !== exp_d) begin
                n_err++; $display("FAIL tx_drain_%0d got=%02h exp=%02h", i, u_if.tx_data, exp_d); end
            txs();
        end
        n_cmp++; if (u_if.tx_send !== 1'b0) begin n_err++; $display("FAIL tx_drain_end got=%b exp=0", u_if.tx_send); end
    endtask

    task automatic test_rx_basic();
        rxb(8'h41);
        rxb(8'h42);
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h05) begin n_err++; $display("FAIL rx_status got=%02h exp=05", u_if.rdata); end
        rd(2'd3);
        n_cmp++; if (u_if.rdata !== 8'h02) begin n_err++; $display("FAIL rx_cnt2 got=%02h exp=02", u_if.rdata); end
        rd(2'd0);
        n_cmp++; if (u_if.rdata !== 8'h41) begin n_err++; $display("FAIL rx_pop0 got=%02h exp=41", u_if.rdata); end
        idle();
        n_cmp++; if (u_if.rdata !== 8'h41) begin n_err++; $display("FAIL rx_rdata_hold got=%02h exp=41", u_if.rdata); end
        rd(2'd0);
        n_cmp++; if (u_if.rdata !== 8'h42) begin n_err++; $display("FAIL rx_pop1 got=%02h exp=42", u_if.rdata); end
        rd(2'd0);
        n_cmp++; if (u_if.rdata !== 8'h00) begin n_err++; $display("FAIL rx_pop_empty got=%02h exp=00", u_if.rdata); end
        rd(2'd3);
        n_cmp++; if (u_if.rdata !== 8'h00) begin n_err++; $display("FAIL rx_cnt0 got=%02h exp=00", u_if.rdata); end
    endtask

    task automatic test_rx_full();
        for (int i = 0; i < DEPTH; i++) rxb(8'(8'h80 + i));
        rd(2'd3);
        n_cmp++; if (u_if.rdata !== 8'(DEPTH)) begin n_err++; $display("FAIL rx_full_cnt got=%02h exp=%02h", u_if.rdata, 8'(DEPTH)); end
        // bus pop and rx edge together on a full FIFO
        step(2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hC5, 1'b1);
        n_cmp++; if (u_if.rdata !== 8'h80) begin n_err++; $display("FAIL rx_full_pop got=%02h exp=80", u_if.rdata); end
        idle();
        rd(2'd3);
        n_cmp++; if (u_if.rdata !== 8'(DEPTH)) begin n_err++; $display("FAIL rx_full_pushpop_cnt got=%02h exp=%02h", u_if.rdata, 8'(DEPTH)); end
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h07) begin n_err++; $display("FAIL rx_full_no_ovr got=%02h exp=07", u_if.rdata); end
        rxb(8'hD0);
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h17) begin n_err++; $display("FAIL rx_ovr_set got=%02h exp=17", u_if.rdata); end
        n_cmp++; if (u_if.irq !== 1'b1) begin n_err++; $display("FAIL rx_ovr_irq got=%b exp=1", u_if.irq); end
        wr(2'd1, 8'h10);
        n_cmp++; if (u_if.irq !== 1'b0) begin n_err++; $display("FAIL rx_ovr_clear_irq got=%b exp=0", u_if.irq); end
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == DEPTH - 1) ? 8'hC5 : 8'(8'h81 + i);
            rd(2'd0);
            n_cmp++; if (u_if.rdata !== exp_d) begin
                n_err++; $display("FAIL rx_drain_%0d got=%02h exp=%02h", i, u_if.rdata, exp_d); end
        end
        rd(2'd3);
        n_cmp++; if (u_if.rdata !== 8'h00) begin n_err++; $display("FAIL rx_drain_cnt got=%02h exp=00", u_if.rdata); end
    endtask

    task automatic test_irq();
        logic seen;
        wr(2'd2, 8'h01);
        n_cmp++; if (u_if.irq !== 1'b0) begin n_err++; $display("FAIL irq_rxie_idle got=%b exp=0", u_if.irq); end
        step(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1);
        seen = u_if.irq;
        idle();
        seen = seen | u_if.irq;
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL irq_rx_rise got=%b exp=1", seen); end
        rd(2'd0);
        n_cmp++; if (u_if.rdata !== 8'h33 || u_if.irq !== 1'b0) begin
            n_err++; $display("FAIL irq_rx_fall got rdata=%02h irq=%b exp rdata=33 irq=0", u_if.rdata, u_if.irq); end
        wr(2'd2, 8'h02);
        n_cmp++; if (u_if.irq !== 1'b1) begin n_err++; $display("FAIL irq_txie got=%b exp=1", u_if.irq); end
        rd(2'd2);
        n_cmp++; if (u_if.rdata !== 8'h02) begin n_err++; $display("FAIL ctrl_read got=%02h exp=02", u_if.rdata); end
        wr(2'd2, 8'h00);
        n_cmp++; if (u_if.irq !== 1'b0) begin n_err++; $display("FAIL irq_off got=%b exp=0", u_if.irq); end
    endtask

    task automatic test_reset_midframe();
        wr(2'd0, 8'h11);
        wr(2'd0, 8'h22);
        rxb(8'h99);
        wr(2'd2, 8'h03);
        rst = 1'b0;
        #1;
        n_cmp++; if (u_if.tx_send !== 1'b0 || u_if.irq !== 1'b0) begin
            n_err++; $display("FAIL midreset_async got send=%b irq=%b exp 0 0", u_if.tx_send, u_if.irq); end
        zero_inputs();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rd(2'd1);
        n_cmp++; if (u_if.rdata !== 8'h04) begin n_err++; $display("FAIL midreset_status got=%02h exp=04", u_if.rdata); end
        rd(2'd2);
        n_cmp++; if (u_if.rdata !== 8'h00) begin n_err++; $display("FAIL midreset_ctrl got=%02h exp=00", u_if.rdata); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic [1:0] a;
            logic [7:0] exp_td;
            a = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
            step(a, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3), 8'($urandom),
                 ($urandom_range(0, 4) == 0), 8'($urandom), ($urandom_range(0, 2) == 0));
            exp_td = (m_tx_q.size() > 0) ? m_tx_q[0] : 8'h00;
            n_cmp++; if (u_if.rdata !== m_rdata) begin
                n_err++; $display("FAIL rand_rdata cyc=%0d got=%02h exp=%02h", c, u_if.rdata, m_rdata); end
            n_cmp++; if (u_if.irq !== m_irq) begin
                n_err++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", c, u_if.irq, m_irq); end
            n_cmp++; if (u_if.tx_send !== (m_tx_q.size() > 0)) begin
                n_err++; $display("FAIL rand_tx_send cyc=%0d got=%b exp=%b", c, u_if.tx_send, (m_tx_q.size() > 0)); end
            n_cmp++; if (u_if.tx_data !== exp_td) begin
                n_err++; $display("FAIL rand_tx_data cyc=%0d got=%02h exp=%02h", c, u_if.tx_data, exp_td); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        zero_inputs();
        model_reset();
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_basic();
        test_rx_full();
        test_irq();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Host-side controller for the existing `uart` core. It drives the core's transmit handshake (`data_in`, `data_send`, `data_sent`) and consumes its receive handshake (`data_out`, `data_received`).
- Buffers bytes in both directions: one TX FIFO and one RX FIFO.
- Exposes a small register interface to the SoC bus, with status flags and a level interrupt.

Parameters:
- FIFO_DEPTH, 16: entries per FIFO. Must be a power of 2, minimum 2.
- CNT_WIDTH, `GET_WIDTH`(FIFO_DEPTH)+1: width of the occupancy counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 RXCNT.
- wr_en  in  1  single-cycle bus write strobe.
- rd_en  in  1  single-cycle bus read strobe.
- wdata  in  8  write data.
- rdata  out  8  read data, registered.
- irq  out  1  level interrupt, registered.
- tx_data  out  8  to uart `data_in`.
- tx_send  out  1  to uart `data_send`.
- tx_sent  in  1  from uart `data_sent`; one-cycle pulse at end of stop bit.
- rx_data  in  8  from uart `data_out`.
- rx_received  in  1  from uart `data_received`.

Behaviour:
- Reset (rst=0, async): both FIFOs empty, pointers and counters 0, CTRL=0, sticky flags 0, rdata=0, irq=0, tx_send=0, tx_data=0.
- A reset mid-frame discards all FIFO contents. The uart core has its own reset.
- TX path:
  - tx_data is always the TX FIFO head (0 when empty). tx_send = TX FIFO not empty, as a level.
  - The core latches tx_data whenever it is idle and tx_send=1. Head is popped only on tx_sent=1, so tx_data stays stable for the whole frame.
  - tx_sent while TX FIFO empty: ignored.
- TX push: wr_en with addr=0 pushes wdata[7:0].
  - If full, the byte is dropped and TX_OVF is set.
  - Exception: a push in the same cycle as a tx_sent pop on a full FIFO is accepted; count is unchanged and TX_OVF is not set.
- RX path:
  - rx_received is edge-detected with a 1-cycle registered copy. A push of rx_data happens on the 0->1 edge only, exactly one byte per frame.
  - If the RX FIFO is full, the byte is dropped and RX_OVR is set.
  - Exception: a push in the same cycle as a bus pop on a full FIFO is accepted and RX_OVR is not set.
- Reads: rd_en drives rdata on the next posedge (1-cycle latency). rdata holds its value when rd_en=0.
  - addr 0, RX FIFO not empty: rdata = RX head, and the head is popped on the same edge.
  - addr 0, RX FIFO empty: rdata = 0x00, no pointer change.
  - addr 1, STATUS: {2'b0, TX_OVF, RX_OVR, tx_full, tx_empty, rx_full, rx_nonempty}, bit 0 being rx_nonempty.
  - addr 2: CTRL, zero-extended.
  - addr 3: RX count, zero-extended to 8 bits.
- Writes:
  - addr 1: writing 1 to bit 4 clears RX_OVR; writing 1 to bit 5 clears TX_OVF (write-1-to-clear).
  - If a set event and a clear happen in the same cycle, set wins.
  - addr 2: CTRL[1:0] = wdata[1:0]. Bit 0 is RX_IE, bit 1 is TX_IE.
  - addr 3: ignored.
- Concurrency: wr_en and rd_en may both be asserted in one cycle and are processed independently. In one cycle each FIFO may see one push and one pop, plus the uart-side event.
- Pointer and count arithmetic:
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Counters are CNT_WIDTH bits and track the range 0..FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- irq is registered: irq <= (RX_IE & rx_nonempty) | (TX_IE & tx_empty) | RX_OVR | TX_OVF, using the next-state values of these terms.

Test Plan:
- Reset value: hold rst=0 with random inputs, release -> rdata=0x00, irq=0, tx_send=0; STATUS read returns 0x04.
- Three writes to DATA (0x55, 0xA3, 0x0F) -> tx_send=1 with tx_data=0x55. Each tx_sent pulse advances tx_data to 0xA3, then 0x0F, then tx_send=0. A loopback uart bench sees exactly those 3 frames in order.
- 17 writes with FIFO_DEPTH=16 and no tx_sent -> TX count stays 16 and STATUS bit 5=1. Write 0x20 to STATUS -> bit 5 clears.
- RX receives 0x41, then 0x42 -> STATUS bit 0=1 and RXCNT=2. DATA reads return 0x41, then 0x42, then 0x00 with RXCNT=0.
- RX FIFO full, with a bus pop and an rx_received edge in the same cycle -> RXCNT stays 16 and RX_OVR stays 0.
- CTRL=0x01, then one RX byte -> irq rises within 2 cycles of the edge and falls the cycle after the DATA read pops it. CTRL=0x02 with empty TX -> irq=1.
